task_enq_responder: RTL and testbench

TASK_ENQ_RESPONDER -- requirements
Module: task_enq_responder

---
 rtl/task_enq_responder.sv | 120 ++++++++++++
 tb/tb_task_enq_responder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/task_enq_responder.sv
// Task-queue enqueue responder: allocates the lowest free slot per request and answers ack/nack.
// Latency 1 cycle to resp_valid/tq_wvalid; s_enq_ready drops only while a response is stalled.
package task_enq_pkg;
    typedef struct packed {
        logic [15:0] func_id;
        logic [31:0] arg;
    } task_t;
    typedef logic [3:0] tsb_entry_id_t;
    typedef logic [7:0] epoch_t;
endpackage

module task_enq_responder
    import task_enq_pkg::*;
#(
    parameter int LOG_TQ_SIZE = 6,
    parameter int TQ_RESERVE  = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   s_enq_valid,
    output logic                   s_enq_ready,
    input  task_t                  s_enq_data,
    input  logic                   s_enq_tied,
    input  tsb_entry_id_t          s_enq_tsb_id,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic                   resp_ack,
    output tsb_entry_id_t          resp_tsb_id,
    output epoch_t                 resp_epoch,
    output logic [LOG_TQ_SIZE-1:0] resp_tq_slot,
    output logic                   tq_wvalid,
    output logic [LOG_TQ_SIZE-1:0] tq_wslot,
    output task_t                  tq_wdata,
    output logic                   tq_wtied,
    input  logic                   tq_free_valid,
    input  logic [LOG_TQ_SIZE-1:0] tq_free_slot,
    output logic [LOG_TQ_SIZE:0]   n_free,
    output logic                   almost_full,
    output logic                   empty
);

    localparam int                   N       = 2 ** LOG_TQ_SIZE;
    localparam logic [LOG_TQ_SIZE:0] N_SLOTS = (LOG_TQ_SIZE + 1)'(N);
    localparam logic [LOG_TQ_SIZE:0] RESERVE = (LOG_TQ_SIZE + 1)'(TQ_RESERVE);
    localparam logic [LOG_TQ_SIZE:0] AF_LIM  = (LOG_TQ_SIZE + 1)'(4);
    localparam logic [LOG_TQ_SIZE:0] ONE     = (LOG_TQ_SIZE + 1)'(1);

    logic [N-1:0]           valid;
    epoch_t                 epoch [N];
    logic                   enq_fire;
    logic                   alloc;
    logic                   free_ok;
    logic [LOG_TQ_SIZE-1:0] alloc_slot;

    // Descending scan so the lowest-index free slot wins.
    always_comb begin
        alloc_slot = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!valid[i]) alloc_slot = LOG_TQ_SIZE'(i);
        end
    end

    assign s_enq_ready = !resp_valid || resp_ready;
    assign enq_fire    = s_enq_valid && s_enq_ready;
    assign alloc       = enq_fire && (s_enq_tied ? (n_free != '0) : (n_free > RESERVE));
    assign free_ok     = tq_free_valid && valid[tq_free_slot];
    assign almost_full = n_free < AF_LIM;
    assign empty       = n_free == N_SLOTS;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid        <= '0;
            for (int i = 0; i < N; i++) epoch[i] <= '0;
            n_free       <= N_SLOTS;
            resp_valid   <= 1'b0;
            resp_ack     <= 1'b0;
            resp_tsb_id  <= '0;
            resp_epoch   <= '0;
            resp_tq_slot <= '0;
            tq_wvalid    <= 1'b0;
            tq_wslot     <= '0;
            tq_wdata     <= '0;
            tq_wtied     <= 1'b0;
        end else begin
            tq_wvalid <= alloc;
            if (alloc) begin
                tq_wslot <= alloc_slot;
                tq_wdata <= s_enq_data;
                tq_wtied <= s_enq_tied;
            end

            if (enq_fire) begin
                resp_valid   <= 1'b1;
                resp_ack     <= alloc;
                resp_tsb_id  <= s_enq_tsb_id;
                resp_tq_slot <= alloc ? alloc_slot : '0;
                resp_epoch   <= alloc ? epoch[alloc_slot] : '0;
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end

            // A freed slot is valid and an allocated one is not, so they never collide.
            for (int i = 0; i < N; i++) begin
                if (alloc && alloc_slot == LOG_TQ_SIZE'(i)) begin
                    valid[i] <= 1'b1;
                end else if (free_ok && tq_free_slot == LOG_TQ_SIZE'(i)) begin
                    valid[i] <= 1'b0;
                    epoch[i] <= epoch[i] + epoch_t'(1);
                end
            end

            case ({free_ok, alloc})
                2'b10:   n_free <= n_free + ONE;
                2'b01:   n_free <= n_free - ONE;
                default: n_free <= n_free;
            endcase
        end
    end

endmodule

// File: tb/tb_task_enq_responder.sv
// Bench for task_enq_responder (4 slots, reserve 1): directed table, stall/reset sequences, random vs model.
module tb_task_enq_responder;
    import task_enq_pkg::*;

    localparam int LOG = 2;
    localparam int NS  = 4;
    localparam int RES = 1;

    logic          clk;
    logic          rstn;
    logic          s_enq_valid;
    logic          s_enq_ready;
    task_t         s_enq_data;
    logic          s_enq_tied;
    tsb_entry_id_t s_enq_tsb_id;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_ack;
    tsb_entry_id_t resp_tsb_id;
    epoch_t        resp_epoch;
    logic [LOG-1:0] resp_tq_slot;
    logic          tq_wvalid;
    logic [LOG-1:0] tq_wslot;
    task_t         tq_wdata;
    logic          tq_wtied;
    logic          tq_free_valid;
    logic [LOG-1:0] tq_free_slot;
    logic [LOG:0]  n_free;
    logic          almost_full;
    logic          empty;

    task_enq_responder #(.LOG_TQ_SIZE(LOG), .TQ_RESERVE(RES)) dut (
        .clk(clk), .rstn(rstn),
        .s_enq_valid(s_enq_valid), .s_enq_ready(s_enq_ready), .s_enq_data(s_enq_data),
        .s_enq_tied(s_enq_tied), .s_enq_tsb_id(s_enq_tsb_id),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_ack(resp_ack),
        .resp_tsb_id(resp_tsb_id), .resp_epoch(resp_epoch), .resp_tq_slot(resp_tq_slot),
        .tq_wvalid(tq_wvalid), .tq_wslot(tq_wslot), .tq_wdata(tq_wdata), .tq_wtied(tq_wtied),
        .tq_free_valid(tq_free_valid), .tq_free_slot(tq_free_slot),
        .n_free(n_free), .almost_full(almost_full), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit rstn; bit ev; bit tied; int tsb; bit fv; int fslot;
        bit rv; bit ack; int slot; int ep; bit wv; int nf;
    } vec_t;

    function automatic vec_t mk(bit r, bit ev, bit tied, int tsb, bit fv, int fs,
                                bit rv, bit ack, int slot, int ep, bit wv, int nf);
        vec_t v;
        v.rstn = r; v.ev = ev; v.tied = tied; v.tsb = tsb; v.fv = fv; v.fslot = fs;
        v.rv = rv; v.ack = ack; v.slot = slot; v.ep = ep; v.wv = wv; v.nf = nf;
        return v;
    endfunction

    // ---------------- reference model ----------------
    bit     m_valid [NS];
    int     m_epoch [NS];
    bit     m_rv, m_ack, m_wv, m_wtied;
    int     m_slot, m_ep, m_tsb, m_wslot;
    task_t  m_wdata;

    function automatic int m_free_count();
        int c = 0;
        for (int i = 0; i < NS; i++) if (!m_valid[i]) c++;
        return c;
    endfunction

    task automatic model_edge();
        int  nf, pick;
        bit  fire, ok, do_free;
        if (!rstn) begin
            for (int i = 0; i < NS; i++) begin m_valid[i] = 0; m_epoch[i] = 0; end
            m_rv = 0; m_wv = 0;
            return;
        end
        nf      = m_free_count();
        fire    = s_enq_valid && (!m_rv || resp_ready);
        do_free = tq_free_valid && m_valid[tq_free_slot];
        m_wv    = 0;
        if (fire) begin
            ok   = s_enq_tied ? (nf > 0) : (nf > RES);
            pick = 0;
            for (int i = NS - 1; i >= 0; i--) if (!m_valid[i]) pick = i;
            m_rv  = 1;
            m_ack = ok;
            m_tsb = int'(s_enq_tsb_id);
            if (ok) begin
                m_slot = pick; m_ep = m_epoch[pick];
                m_wv = 1; m_wslot = pick; m_wdata = s_enq_data; m_wtied = s_enq_tied;
                m_valid[pick] = 1;
            end else begin
                m_slot = 0; m_ep = 0;
            end
        end else if (resp_ready) begin
            m_rv = 0;
        end
        if (do_free) begin
            m_valid[tq_free_slot] = 0;
            m_epoch[tq_free_slot] = (m_epoch[tq_free_slot] + 1) % 256;
        end
    endtask

    task automatic model_check();
        int nf = m_free_count();
        chk("m_ready", 64'(s_enq_ready), 64'(!m_rv || resp_ready));
        chk("m_resp_valid", 64'(resp_valid), 64'(m_rv));
        if (m_rv) begin
            chk("m_resp_ack", 64'(resp_ack), 64'(m_ack));
            chk("m_resp_tsb", 64'(resp_tsb_id), 64'(m_tsb));
            chk("m_resp_slot", 64'(resp_tq_slot), 64'(m_slot));
            chk("m_resp_epoch", 64'(resp_epoch), 64'(m_ep));
        end
        chk("m_wvalid", 64'(tq_wvalid), 64'(m_wv));
        if (m_wv) begin
            chk("m_wslot", 64'(tq_wslot), 64'(m_wslot));
            chk("m_wdata", 64'(tq_wdata), 64'(m_wdata));
            chk("m_wtied", 64'(tq_wtied), 64'(m_wtied));
        end
        chk("m_n_free", 64'(n_free), 64'(nf));
        chk("m_almost_full", 64'(almost_full), 64'(nf < 4));
        chk("m_empty", 64'(empty), 64'(nf == NS));
    endtask

    task automatic reset_dut();
        rstn = 1'b0; s_enq_valid = 1'b0; tq_free_valid = 1'b0; resp_ready = 1'b1;
        tick(); tick();
        rstn = 1'b1;
        tick();
        chk("ready_after_reset", 64'(s_enq_ready), 64'd1);
    endtask

    vec_t  tbl[$];
    task_t cur;

    initial begin
        rstn = 1'b0; s_enq_valid = 1'b0; s_enq_data = '0; s_enq_tied = 1'b0; s_enq_tsb_id = '0;
        resp_ready = 1'b1; tq_free_valid = 1'b0; tq_free_slot = '0;
        @(negedge clk);

        //            rstn ev tied tsb fv fs | rv ack slot ep wv nf
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 4));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 4));
        tbl.push_back(mk(1, 1, 1, 5, 0, 0,   1, 1, 0, 0, 1, 3));
        tbl.push_back(mk(1, 1, 1, 1, 0, 0,   1, 1, 1, 0, 1, 2));
        tbl.push_back(mk(1, 1, 1, 2, 0, 0,   1, 1, 2, 0, 1, 1));
        tbl.push_back(mk(1, 1, 0, 3, 0, 0,   1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 4, 0, 0,   1, 1, 3, 0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 6, 0, 0,   1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 7, 0, 0,   1, 1, 1, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 8, 0, 0,   1, 1, 1, 2, 1, 0));
        tbl.push_back(mk(1, 1, 1, 9, 1, 0,   1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 9, 0, 0,   1, 1, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 3,   0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1,10, 1, 2,   1, 1, 3, 1, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1));

        foreach (tbl[k]) begin
            cur = {16'(k), 32'hA000_0000 + 32'(k)};
            rstn = tbl[k].rstn; s_enq_valid = tbl[k].ev; s_enq_tied = tbl[k].tied;
            s_enq_tsb_id = 4'(tbl[k].tsb); s_enq_data = cur; resp_ready = 1'b1;
            tq_free_valid = tbl[k].fv; tq_free_slot = 2'(tbl[k].fslot);
            tick();
            chk($sformatf("t%0d_ready", k), 64'(s_enq_ready), 64'd1);
            chk($sformatf("t%0d_resp_valid", k), 64'(resp_valid), 64'(tbl[k].rv));
            if (tbl[k].rv) begin
                chk($sformatf("t%0d_ack", k), 64'(resp_ack), 64'(tbl[k].ack));
                chk($sformatf("t%0d_slot", k), 64'(resp_tq_slot), 64'(tbl[k].slot));
                chk($sformatf("t%0d_epoch", k), 64'(resp_epoch), 64'(tbl[k].ep));
                chk($sformatf("t%0d_tsb", k), 64'(resp_tsb_id), 64'(tbl[k].tsb));
            end
            chk($sformatf("t%0d_wvalid", k), 64'(tq_wvalid), 64'(tbl[k].wv));
            if (tbl[k].wv) begin
                chk($sformatf("t%0d_wslot", k), 64'(tq_wslot), 64'(tbl[k].slot));
                chk($sformatf("t%0d_wdata", k), 64'(tq_wdata), 64'(cur));
                chk($sformatf("t%0d_wtied", k), 64'(tq_wtied), 64'(tbl[k].tied));
            end
            chk($sformatf("t%0d_n_free", k), 64'(n_free), 64'(tbl[k].nf));
            chk($sformatf("t%0d_almost_full", k), 64'(almost_full), 64'(tbl[k].nf < 4));
            chk($sformatf("t%0d_empty", k), 64'(empty), 64'(tbl[k].nf == NS));
        end
        s_enq_valid = 1'b0; tq_free_valid = 1'b0;

        // Response stall: request held while resp_ready is low, accepted the cycle it rises.
        reset_dut();
        s_enq_valid = 1'b1; s_enq_tied = 1'b1; s_enq_tsb_id = 4'd1; resp_ready = 1'b0;
        tick();
        s_enq_tsb_id = 4'd2;
        for (int c = 0; c < 3; c++) begin
            chk("stall_ready", 64'(s_enq_ready), 64'd0);
            chk("stall_valid", 64'(resp_valid), 64'd1);
            chk("stall_ack", 64'(resp_ack), 64'd1);
            chk("stall_tsb", 64'(resp_tsb_id), 64'd1);
            chk("stall_slot", 64'(resp_tq_slot), 64'd0);
            chk("stall_epoch", 64'(resp_epoch), 64'd0);
            chk("stall_n_free", 64'(n_free), 64'd3);
            if (c > 0) chk("stall_wvalid", 64'(tq_wvalid), 64'd0);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        chk("unstall_ready", 64'(s_enq_ready), 64'd1);
        tick();
        chk("unstall_valid", 64'(resp_valid), 64'd1);
        chk("unstall_tsb", 64'(resp_tsb_id), 64'd2);
        chk("unstall_slot", 64'(resp_tq_slot), 64'd1);
        chk("unstall_wvalid", 64'(tq_wvalid), 64'd1);
        chk("unstall_n_free", 64'(n_free), 64'd2);
        s_enq_valid = 1'b0;
        tick();
        chk("drain_valid", 64'(resp_valid), 64'd0);

        // Reset while a response is pending drops it.
        s_enq_valid = 1'b1; s_enq_tsb_id = 4'd3; resp_ready = 1'b0;
        tick();
        chk("prerst_valid", 64'(resp_valid), 64'd1);
        chk("prerst_slot", 64'(resp_tq_slot), 64'd2);
        s_enq_valid = 1'b0; rstn = 1'b0;
        tick();
        chk("rst_valid", 64'(resp_valid), 64'd0);
        chk("rst_n_free", 64'(n_free), 64'd4);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_wvalid", 64'(tq_wvalid), 64'd0);
        rstn = 1'b1; resp_ready = 1'b1;
        tick();
        chk("rel_ready", 64'(s_enq_ready), 64'd1);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rstn          = (c < 2) ? 1'b0 : ($urandom_range(0, 199) != 0);
            s_enq_valid   = $urandom_range(0, 1);
            s_enq_tied    = $urandom_range(0, 1);
            s_enq_tsb_id  = 4'($urandom);
            s_enq_data    = {16'($urandom), 32'($urandom)};
            resp_ready    = ($urandom_range(0, 9) < 7);
            tq_free_valid = ($urandom_range(0, 9) < 4);
            tq_free_slot  = 2'($urandom);
            model_edge();
            tick();
            if (c >= 2) model_check();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
